sound_reg_file: RTL
===================

Name: sound_reg_file

Overview:
- CPU-side writer/reader for the four sound channels' control registers. It sits between the IO bus decoder and the square1/square2/wave/noise channel instances.
- Decodes halfword bus accesses at IO offsets 0x60–0x9E.
- Drives the NRxx byte registers and wave RAM halfwords that the channels consume.
- Generates one-cycle trigger pulses and implements the master sound enable (NR52) clear behaviour.

Parameters:
- ADDR_W, 8, width of IO offset (byte address within 0x0400_0000 page, low byte).

Ports:
- system_clock  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe, one access per cycle
- rd_en  in  1  read strobe
- addr  in  ADDR_W  byte offset; bit 0 ignored (halfword aligned)
- wr_data  in  16  write data
- byte_en  in  2  byte lane enables [0]=low byte, [1]=high byte
- rd_data  out  16  registered read data
- rd_valid  out  1  high one cycle after rd_en
- ch_active  in  4  channel-on status from channels 1–4, reflected in NR52[3:0]
- NR10,NR11,NR12,NR13,NR14,NR21,NR22,NR23,NR24,NR30,NR31,NR32,NR33,NR34,NR41,NR42,NR43,NR44,NR50,NR51  out  8 each  channel/mixer registers
- addr_0x90..addr_0x9E  out  16 each  wave RAM halfwords (8 ports)
- trigger  out  4  one-cycle restart pulse per channel
- master_enable  out  1  NR52 bit 7

Behaviour:
- Reset (async): every NRxx output, wave RAM, rd_data, rd_valid, trigger and master_enable go to 0.
- Address map, as {high byte, low byte}:
  - 0x60 {–, NR10}; 0x62 {NR12, NR11}; 0x64 {NR14, NR13}
  - 0x68 {NR22, NR21}; 0x6C {NR24, NR23}
  - 0x70 {–, NR30}; 0x72 {NR32, NR31}; 0x74 {NR34, NR33}
  - 0x78 {NR42, NR41}; 0x7C {NR44, NR43}
  - 0x80 {NR51, NR50}; 0x84 {–, NR52}; 0x90–0x9E wave RAM
- Any other address: writes ignored, reads return 0.
- Writes: each enabled lane updates its byte on the clock edge after wr_en. Disabled lanes are held.
- Trigger:
  - A write whose enabled lane carries NR14/NR24/NR34/NR44 with data bit 7 = 1 raises trigger[n] for exactly one cycle, the cycle after the write.
  - The stored NRx4 bit 7 is 1 during that same cycle only, then clears to 0. The other NRx4 bits persist.
  - Back-to-back trigger writes produce back-to-back pulses, with no merging loss.
- Master enable:
  - A write to 0x84 low lane sets master_enable = data bit 7. Bits 6:0 are not stored.
  - While master_enable = 0: writes to 0x60–0x80 are ignored and no triggers fire. Wave RAM stays writable.
  - On a 1→0 write, all NR10–NR51 registers clear to 0 on that edge, and any trigger pending the same cycle is suppressed.
  - A 0→1 write leaves the registers at 0.
- Reads: rd_data/rd_valid are registered, one-cycle latency, back-to-back allowed. A read and a write to the same address in the same cycle return the pre-write value.
- Read masks (write-only bits read 0):
  - NR11/NR21 read bits 7:6 only.
  - NR13, NR23, NR31, NR33, NR41 read 0.
  - NRx4 reads bit 6 only.
  - NR10 reads bits 6:0.
  - NR30 reads bit 7.
  - NR32 reads bits 7:5.
  - NR52 reads {master_enable, 3'b0, ch_active}.
  - Unmapped lanes ("–") read 0.
  - Everything else reads the full byte.
- Reset mid-operation: pending trigger and rd_valid are dropped immediately.

Test Plan:
- Reset, then read 0x84 -> rd_valid next cycle, rd_data=0x0000. Write 0x84=0x0080 -> master_enable=1; read 0x84 with ch_active=4'b0101 -> 0x0085.
- With master_enable=1, write 0x64=0x87D6 with byte_en=11 -> NR13=0xD6, trigger[0]=1 for one cycle, NR14=0x87 then 0x07; read 0x64 -> 0x0000.
- Write 0x62=0xF3C5 with byte_en=01 -> NR11=0xC5, NR12 unchanged. Read 0x62 -> 0x00C0.
- With master_enable=0, write 0x68=0x1234 -> NR21/NR22 stay 0. Write 0x90=0xBEEF -> addr_0x90=0xBEEF.
- Set NR50=0x77 and write 0x7C=0x8011. In the next cycle write 0x84=0x0000 -> all NRxx=0, trigger[3] remains 0 throughout, addr_0x90 retains its value.
- Read 0x72 in the same cycle as write 0x72=0x6000 (old NR32=0x20) -> rd_data=0x2000; subsequent read -> 0x6000. Assert reset mid-write -> all outputs 0 immediately.

Source files
------------

// File: rtl/sound_reg_file.sv
// Sound channel register file: decodes halfword IO accesses at 0x60-0x9E into NRxx bytes,
// wave RAM halfwords, one-cycle trigger pulses and the NR52 master enable.
module sound_reg_file #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic              system_clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [15:0]       wr_data,
   input  logic [1:0]        byte_en,
   output logic [15:0]       rd_data,
   output logic              rd_valid,
   input  logic [3:0]        ch_active,
   output logic [7:0]        NR10, NR11, NR12, NR13, NR14,
   output logic [7:0]        NR21, NR22, NR23, NR24,
   output logic [7:0]        NR30, NR31, NR32, NR33, NR34,
   output logic [7:0]        NR41, NR42, NR43, NR44,
   output logic [7:0]        NR50, NR51,
   output logic [15:0]       addr_0x90, addr_0x92, addr_0x94, addr_0x96,
   output logic [15:0]       addr_0x98, addr_0x9A, addr_0x9C, addr_0x9E,
   output logic [3:0]        trigger,
   output logic              master_enable
);

   localparam int unsigned NumNr = 20;
   typedef logic [4:0] idx_t;

   logic [7:0]        nr_q [NumNr];
   logic [7:0]        nr_d [NumNr];
   logic [15:0]       wave_q [8];
   logic [15:0]       wave_d [8];
   logic [3:0]        trig_q, trig_d;
   logic              me_q, me_d;
   logic [15:0]       rd_data_q, rd_data_d;
   logic              rd_valid_q;

   logic [ADDR_W-1:0] a_word;
   logic              lo_hit, hi_hit, hi_x4, is_nr52, is_wave, master_clear;
   idx_t              lo_idx, hi_idx;
   logic [1:0]        x4_ch;
   logic              unused_addr0;

   assign unused_addr0 = addr[0];
   assign a_word       = {addr[ADDR_W-1:1], 1'b0};

   // Lane decode: nr_q index carried by each byte lane of the addressed halfword.
   always_comb begin
      lo_hit  = 1'b0;
      hi_hit  = 1'b0;
      hi_x4   = 1'b0;
      lo_idx  = '0;
      hi_idx  = '0;
      x4_ch   = '0;
      is_nr52 = (a_word == ADDR_W'('h84));
      is_wave = (a_word >= ADDR_W'('h90)) && (a_word <= ADDR_W'('h9E));
      case (a_word)
         ADDR_W'('h60): begin lo_hit = 1'b1; lo_idx = 5'd0; end
         ADDR_W'('h62): begin lo_hit = 1'b1; lo_idx = 5'd1; hi_hit = 1'b1; hi_idx = 5'd2; end
         ADDR_W'('h64): begin
            lo_hit = 1'b1; lo_idx = 5'd3; hi_hit = 1'b1; hi_idx = 5'd4; hi_x4 = 1'b1; x4_ch = 2'd0;
         end
         ADDR_W'('h68): begin lo_hit = 1'b1; lo_idx = 5'd5; hi_hit = 1'b1; hi_idx = 5'd6; end
         ADDR_W'('h6C): begin
            lo_hit = 1'b1; lo_idx = 5'd7; hi_hit = 1'b1; hi_idx = 5'd8; hi_x4 = 1'b1; x4_ch = 2'd1;
         end
         ADDR_W'('h70): begin lo_hit = 1'b1; lo_idx = 5'd9; end
         ADDR_W'('h72): begin lo_hit = 1'b1; lo_idx = 5'd10; hi_hit = 1'b1; hi_idx = 5'd11; end
         ADDR_W'('h74): begin
            lo_hit = 1'b1; lo_idx = 5'd12; hi_hit = 1'b1; hi_idx = 5'd13; hi_x4 = 1'b1; x4_ch = 2'd2;
         end
         ADDR_W'('h78): begin lo_hit = 1'b1; lo_idx = 5'd14; hi_hit = 1'b1; hi_idx = 5'd15; end
         ADDR_W'('h7C): begin
            lo_hit = 1'b1; lo_idx = 5'd16; hi_hit = 1'b1; hi_idx = 5'd17; hi_x4 = 1'b1; x4_ch = 2'd3;
         end
         ADDR_W'('h80): begin lo_hit = 1'b1; lo_idx = 5'd18; hi_hit = 1'b1; hi_idx = 5'd19; end
         default: ;
      endcase
   end

   function automatic logic [7:0] rd_mask(input idx_t idx);
      case (idx)
         5'd0:                          return 8'h7F;
         5'd1, 5'd5:                    return 8'hC0;
         5'd3, 5'd7, 5'd10, 5'd12, 5'd14: return 8'h00;
         5'd4, 5'd8, 5'd13, 5'd17:      return 8'h40;
         5'd9:                          return 8'h80;
         5'd11:                         return 8'hE0;
         default:                       return 8'hFF;
      endcase
   endfunction

   assign master_clear = wr_en && is_nr52 && byte_en[0] && me_q && !wr_data[7];

   always_comb begin
      nr_d   = nr_q;
      wave_d = wave_q;
      trig_d = '0;
      me_d   = me_q;
      // NRx4 bit 7 is only a strobe; it survives one cycle.
      nr_d[4][7]  = 1'b0;
      nr_d[8][7]  = 1'b0;
      nr_d[13][7] = 1'b0;
      nr_d[17][7] = 1'b0;
      if (wr_en) begin
         if (is_nr52 && byte_en[0]) me_d = wr_data[7];
         if (is_wave) begin
            if (byte_en[0]) wave_d[addr[3:1]][7:0]  = wr_data[7:0];
            if (byte_en[1]) wave_d[addr[3:1]][15:8] = wr_data[15:8];
         end
         if (me_q) begin
            if (lo_hit && byte_en[0]) nr_d[lo_idx] = wr_data[7:0];
            if (hi_hit && byte_en[1]) begin
               nr_d[hi_idx] = wr_data[15:8];
               if (hi_x4 && wr_data[15]) trig_d[x4_ch] = 1'b1;
            end
         end
      end
      if (master_clear) begin
         for (int i = 0; i < NumNr; i++) nr_d[i] = '0;
         trig_d = '0;
      end
   end

   always_comb begin
      rd_data_d = '0;
      if (lo_hit)  rd_data_d[7:0]  = nr_q[lo_idx] & rd_mask(lo_idx);
      if (hi_hit)  rd_data_d[15:8] = nr_q[hi_idx] & rd_mask(hi_idx);
      if (is_nr52) rd_data_d[7:0]  = {me_q, 3'b000, ch_active};
      if (is_wave) rd_data_d       = wave_q[addr[3:1]];
   end

   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NumNr; i++) nr_q[i] <= '0;
         for (int i = 0; i < 8; i++) wave_q[i] <= '0;
         trig_q     <= '0;
         me_q       <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         nr_q       <= nr_d;
         wave_q     <= wave_d;
         trig_q     <= trig_d;
         me_q       <= me_d;
         rd_valid_q <= rd_en;
         if (rd_en) rd_data_q <= rd_data_d;
      end
   end

   // A pulse already out this cycle is squashed when sound is switched off in the same cycle.
   assign trigger       = trig_q & ~{4{master_clear}};
   assign master_enable = me_q;
   assign rd_data       = rd_data_q;
   assign rd_valid      = rd_valid_q;

   assign NR10 = nr_q[0];
   assign NR11 = nr_q[1];
   assign NR12 = nr_q[2];
   assign NR13 = nr_q[3];
   assign NR14 = nr_q[4];
   assign NR21 = nr_q[5];
   assign NR22 = nr_q[6];
   assign NR23 = nr_q[7];
   assign NR24 = nr_q[8];
   assign NR30 = nr_q[9];
   assign NR31 = nr_q[10];
   assign NR32 = nr_q[11];
   assign NR33 = nr_q[12];
   assign NR34 = nr_q[13];
   assign NR41 = nr_q[14];
   assign NR42 = nr_q[15];
   assign NR43 = nr_q[16];
   assign NR44 = nr_q[17];
   assign NR50 = nr_q[18];
   assign NR51 = nr_q[19];

   assign addr_0x90 = wave_q[0];
   assign addr_0x92 = wave_q[1];
   assign addr_0x94 = wave_q[2];
   assign addr_0x96 = wave_q[3];
   assign addr_0x98 = wave_q[4];
   assign addr_0x9A = wave_q[5];
   assign addr_0x9C = wave_q[6];
   assign addr_0x9E = wave_q[7];

endmodule
